if_prefetch: RTL and testbench

Parametrised instruction-fetch stage for the five-stage pipelined CPU; successor to the single-instruction IF stage. Issues sequential fetch requests to instruction memory through a request/grant/response handshake that tolerates variable latency, buffers up to DEPTH instructions in a prefetch queue, and delivers one instruction plus its PC per cycle to ID. Branch/Jump redirects flush the queue and discard in-flight responses; IFWrite=0 stalls delivery without stopping prefetch.

---
 rtl/if_prefetch_pkg.sv | 10 +
 rtl/if_prefetch_fetch_fifo.sv | 57 +++++
 rtl/if_prefetch.sv | 123 ++++++++++++
 tb/tb_if_prefetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch stage: NOP encoding, reset PC,
// default datapath width and the sequential PC step.
package if_prefetch_pkg;

   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam int unsigned RESET_PC_DEFAULT = 0;
   localparam int unsigned PC_INC           = 4;
   localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instruction} entries with
// flush-all clear. Power-of-two depth so pointers wrap naturally.
module if_prefetch_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           clear,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; the head is masked by empty at the top.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with prefetch queue: issues sequential requests over
// a req/gnt/rvalid interface, buffers responses and hands one per cycle to ID.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int unsigned    XLEN     = XLEN_DEFAULT,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Branch,
   input  logic [XLEN-1:0] BranchAddr,
   input  logic            Jump,
   input  logic [XLEN-1:0] JumpAddr,
   input  logic            IFWrite,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] Instruction_if,
   output logic [XLEN-1:0] PC,
   output logic            IF_flush
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0]   fetch_pc, fetch_pc_n;
   logic [XLEN-1:0]   resp_pc, resp_pc_n;
   logic [CW-1:0]     outstanding, outstanding_n;
   logic [CW-1:0]     discard, discard_n;
   logic [CW-1:0]     count;
   logic [SW-1:0]     count_sum;
   logic [SW-1:0]     flight_sum;
   logic              redirect;
   logic [XLEN-1:0]   sel_addr;
   logic [XLEN-1:0]   target;
   logic              issue;
   logic              drop;
   logic              accept;
   logic              push;
   logic              pop;
   logic              empty;
   logic              full;
   logic [2*XLEN-1:0] head;

   assign redirect   = Branch | Jump;
   assign sel_addr   = Branch ? BranchAddr : JumpAddr;
   assign target     = sel_addr & ~XLEN'(3);
   assign IF_flush   = redirect;

   assign count_sum  = SW'(count) + SW'(outstanding);
   assign flight_sum = SW'(outstanding) + SW'(discard);

   // Request only while every possible response has a guaranteed queue slot.
   assign imem_req   = reset && !redirect
                       && (count_sum < SW'(DEPTH))
                       && (flight_sum < SW'(DEPTH));
   assign imem_addr  = fetch_pc;
   assign issue      = imem_req && imem_gnt;

   assign drop       = imem_rvalid && (discard != '0);
   assign accept     = imem_rvalid && !redirect && (discard == '0) && (outstanding != '0);
   assign push       = accept && (!full || pop);
   assign pop        = if_valid && IFWrite && !redirect;

   assign if_valid       = !empty;
   assign Instruction_if = if_valid ? head[XLEN-1:0] : XLEN'(NOP);
   assign PC             = if_valid ? head[2*XLEN-1:XLEN] : resp_pc;

   if_prefetch_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (redirect),
      .wdata ({resp_pc, imem_rdata}),
      .rdata (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   // A redirect turns every kept in-flight request into one to be dropped.
   always_comb begin
      fetch_pc_n    = fetch_pc;
      resp_pc_n     = resp_pc;
      outstanding_n = outstanding;
      discard_n     = discard;
      if (redirect) begin
         fetch_pc_n    = target;
         resp_pc_n     = target;
         outstanding_n = '0;
         discard_n     = CW'(flight_sum - SW'(imem_rvalid && (flight_sum != '0)));
      end else begin
         if (issue)  fetch_pc_n = fetch_pc + XLEN'(PC_INC);
         if (drop)   discard_n  = discard - CW'(1);
         if (accept) resp_pc_n  = resp_pc + XLEN'(PC_INC);
         outstanding_n = outstanding + CW'(issue) - CW'(accept);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         fetch_pc    <= fetch_pc_n;
         resp_pc     <= resp_pc_n;
         outstanding <= outstanding_n;
         discard     <= discard_n;
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: variable-latency memory model plus a reference model
// of the delivered instruction stream, request eligibility and addresses.
module tb_if_prefetch;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   typedef struct {
      logic [31:0] addr;
      int          ready;
      bit          stale;
   } mreq_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Branch = 1'b0;
   logic [31:0] BranchAddr = '0;
   logic        Jump = 1'b0;
   logic [31:0] JumpAddr = '0;
   logic        IFWrite = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] Instruction_if;
   logic [31:0] PC;
   logic        IF_flush;

   int          n_tests = 0;
   int          n_fail  = 0;

   mreq_t       mq[$];
   int          cyc = 0;
   int          kept = 0;
   int          avail = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_fetch = RESET_PC;

   if_prefetch #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .Branch         (Branch),
      .BranchAddr     (BranchAddr),
      .Jump           (Jump),
      .JumpAddr       (JumpAddr),
      .IFWrite        (IFWrite),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .Instruction_if (Instruction_if),
      .PC             (PC),
      .IF_flush       (IF_flush)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs and memory response, check, then advance the model.
   task automatic step(input logic br, input logic [31:0] ba, input logic jp,
                       input logic [31:0] ja, input logic ifw, input logic g, input int lat);
      logic        redir, rv, e_req, e_valid, deliver;
      logic [31:0] tgt;
      mreq_t       head;
      Branch = br; BranchAddr = ba; Jump = jp; JumpAddr = ja;
      IFWrite = ifw; imem_gnt = g;
      rv = (mq.size() > 0) && (mq[0].ready <= cyc);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(mq[0].addr) : $urandom;
      #1;
      redir   = br | jp;
      tgt     = (br ? ba : ja) & 32'hFFFF_FFFC;
      e_req   = !redir && (kept < DEPTH) && (mq.size() < DEPTH);
      e_valid = (avail > 0);
      check("flush", 64'(IF_flush), 64'(redir));
      check("req", 64'(imem_req), 64'(e_req));
      check("addr", 64'(imem_addr), 64'(exp_fetch));
      check("valid", 64'(if_valid), 64'(e_valid));
      check("pc", 64'(PC), 64'(exp_pc));
      check("instr", 64'(Instruction_if), 64'(e_valid ? mem_word(exp_pc) : 32'h0));
      check("inflight_le_depth", 64'(mq.size() <= DEPTH), 64'(1));
      @(posedge clk);
      head.stale = 1'b1;
      if (rv) head = mq.pop_front();
      if (redir) begin
         foreach (mq[i]) mq[i].stale = 1'b1;
         exp_fetch = tgt;
         exp_pc    = tgt;
         kept      = 0;
         avail     = 0;
      end else begin
         deliver = e_valid && ifw;
         if (rv && !head.stale) avail++;
         if (deliver) begin
            avail--;
            kept--;
            exp_pc = exp_pc + 32'd4;
         end
         if (e_req && g) begin
            mq.push_back('{addr: exp_fetch, ready: cyc + lat, stale: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
            kept++;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n, input logic ifw, input int lat);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, ifw, 1'b1, lat);
   endtask

   task automatic do_reset();
      Branch = 1'b0; Jump = 1'b0; imem_rvalid = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_valid", 64'(if_valid), 64'(0));
      check("rst_instr", 64'(Instruction_if), 64'(0));
      check("rst_pc", 64'(PC), 64'(RESET_PC));
      check("rst_req", 64'(imem_req), 64'(0));
      check("rst_addr", 64'(imem_addr), 64'(RESET_PC));
      for (int i = 0; i < 3; i++) begin
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
         imem_gnt    = 1'b1;
         @(posedge clk);
         #1;
         check("rst_hold_valid", 64'(if_valid), 64'(0));
         check("rst_hold_req", 64'(imem_req), 64'(0));
      end
      imem_rvalid = 1'b0;
      mq.delete();
      kept = 0; avail = 0;
      exp_pc = RESET_PC; exp_fetch = RESET_PC;
      reset = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();

      // Streaming with single-cycle memory.
      idle(20, 1'b1, 1);

      // Stall for 10 cycles: head frozen, requests stop once the queue is committed.
      idle(10, 1'b0, 1);
      check("stall_req_low", 64'(imem_req), 64'(0));
      idle(10, 1'b1, 1);

      // Branch to 0x20 with 3-cycle memory and several requests in flight.
      idle(8, 1'b1, 3);
      step(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1, 3);
      for (int i = 0; i < 20 && !if_valid; i++) idle(1, 1'b1, 3);
      check("br_first_valid", 64'(if_valid), 64'(1));
      check("br_first_pc", 64'(PC), 64'(32'h20));
      idle(10, 1'b1, 1);

      // Branch and Jump together: Branch wins, low bits cleared, head at N+3.
      step(1'b1, 32'h43, 1'b1, 32'h80, 1'b1, 1'b1, 1);
      idle(2, 1'b1, 1);
      check("brjp_valid", 64'(if_valid), 64'(1));
      check("brjp_pc", 64'(PC), 64'(32'h40));
      idle(6, 1'b1, 1);

      // Fetch address wraps past the top of the address space.
      step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
      idle(2, 1'b1, 1);
      check("wrap_addr", 64'(imem_addr), 64'(32'h0));
      idle(8, 1'b1, 1);

      // Random traffic: grant, latency, stalls, redirects; one mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         logic        br, jp, ifw, g;
         logic [31:0] ba, ja;
         br  = ($urandom_range(0, 99) < 3);
         jp  = ($urandom_range(0, 99) < 3);
         ba  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
         ja  = $urandom;
         ifw = ($urandom_range(0, 3) != 0);
         g   = ($urandom_range(0, 1) == 1);
         step(br, ba, jp, ja, ifw, g, int'($urandom_range(1, 4)));
         if (i == 1500) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
